// File: rtl/lector_encoder.sv
// Quadrature encoder reader: synchronises and debounces the A/B channels,
// decodes 4x quadrature into a wrapping signed position, measures a signed
// per-window velocity and flags illegal (double-bit) transitions.
//
// Output timing: vel_valid is a one-cycle strobe with no back-pressure.
// velocity and moving change only in the cycle vel_valid is high and hold
// otherwise, so a consumer may sample them on the strobe or at any later time.
// fsm_state is a debug view of the decoder state (0 = INIT, 1 = TRACK).
module lector_encoder #(
  parameter int FILTER_CYCLES = 4,
  parameter int WINDOW_CYCLES = 5_000_000,
  parameter int POS_W         = 16,
  parameter int VEL_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    clear_pos,
  output logic signed [POS_W-1:0] position,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    direction,
  output logic                    moving,
  output logic                    error,
  output logic                    fsm_state
);

  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam int WCW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [FCW-1:0] F_CNT  = FCW'(FILTER_CYCLES);
  localparam logic [WCW-1:0] W_LAST = WCW'(WINDOW_CYCLES - 1);

  typedef enum logic {
    S_INIT  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser. Channel vectors are packed as {B, A}.
  // fill_q marks when s2_q holds a real pin sample rather than its reset
  // value, so the filter never qualifies a level the pins never had.
  // ---------------------------------------------------------------------
  logic [1:0] s1_q, s2_q;
  logic [1:0] fill_q;

  // Two-flop synchroniser per channel plus pipeline-fill tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 2'b00;
      s2_q   <= 2'b00;
      fill_q <= 2'b00;
    end else begin
      s1_q   <= {enc_b, enc_a};
      s2_q   <= s1_q;
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel filter. cand_q is the level of the current run of equal
  // samples and run_q its length (saturating at FILTER_CYCLES). Once a run
  // reaches FILTER_CYCLES the level is accepted into flt_q; qual_q records
  // that the channel has produced at least one accepted level.
  // ---------------------------------------------------------------------
  logic [1:0]     cand_q, cand_d;
  logic [1:0]     flt_q, flt_d;
  logic [1:0]     qual_q, qual_d;
  logic [FCW-1:0] run_q [2];
  logic [FCW-1:0] run_d [2];

  // Run-length tracking and level acceptance for both channels
  always_comb begin
    cand_d = cand_q;
    flt_d  = flt_q;
    qual_d = qual_q;
    for (int ch = 0; ch < 2; ch++) begin
      run_d[ch] = run_q[ch];
      if (fill_q[1]) begin
        if (s2_q[ch] == cand_q[ch]) begin
          if (run_q[ch] != F_CNT) begin
            run_d[ch] = run_q[ch] + 1'b1;
          end
        end else begin
          cand_d[ch] = s2_q[ch];
          run_d[ch]  = FCW'(1);
        end
        if (run_d[ch] == F_CNT) begin
          flt_d[ch]  = s2_q[ch];
          qual_d[ch] = 1'b1;
        end
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= 2'b00;
      flt_q  <= 2'b00;
      qual_q <= 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        run_q[ch] <= '0;
      end
    end else begin
      cand_q <= cand_d;
      flt_q  <= flt_d;
      qual_q <= qual_d;
      for (int ch = 0; ch < 2; ch++) begin
        run_q[ch] <= run_d[ch];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Quadrature decode. {B,A} maps onto a 2-bit cycle position
  // (00->0, 01->1, 11->2, 10->3); the modulo-4 difference to the baseline
  // classifies the transition: 1 forward, 3 reverse, 2 illegal, 0 none.
  // ---------------------------------------------------------------------
  function automatic logic [1:0] cycle_pos(input logic [1:0] ba);
    logic [1:0] p;
    case (ba)
      2'b00:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  state_t         state_q;
  logic [1:0]     base_q;
  logic [POS_W-1:0] pos_q;
  logic           dir_q;
  logic           err_q;

  logic [1:0] delta;
  logic       is_track;
  logic       step_fwd, step_rev, step_bad;

  assign delta    = cycle_pos(flt_q) - cycle_pos(base_q);
  assign is_track = (state_q == S_TRACK);
  assign step_fwd = is_track && (delta == 2'd1);
  assign step_rev = is_track && (delta == 2'd3);
  assign step_bad = is_track && (delta == 2'd2);

  // Decoder FSM: baseline capture, position, direction and sticky error.
  // clear_pos is applied last so it overrides a step or error in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      base_q  <= 2'b00;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (&qual_q) begin
            base_q  <= flt_q;
            state_q <= S_TRACK;
          end
        end
        S_TRACK: begin
          if (flt_q != base_q) begin
            base_q <= flt_q;
          end
          if (step_fwd) begin
            pos_q <= pos_q + 1'b1;
            dir_q <= 1'b1;
          end
          if (step_rev) begin
            pos_q <= pos_q - 1'b1;
            dir_q <= 1'b0;
          end
          if (step_bad) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= S_INIT;
      endcase
      if (clear_pos) begin
        pos_q <= '0;
        err_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Velocity window. The accumulator is one bit wider than the output and
  // saturates rather than wrapping; the reported value is further clamped
  // to the signed VEL_W range. A step landing on the terminal count seeds
  // the next window's accumulator.
  // ---------------------------------------------------------------------
  logic [WCW-1:0]   win_q;
  logic [VEL_W:0]   acc_q;
  logic [VEL_W-1:0] vel_q;
  logic             vel_valid_q;
  logic             moving_q;

  logic             tc;
  logic [VEL_W:0]   step_ext;
  logic [VEL_W+1:0] acc_sum;
  logic [VEL_W:0]   acc_next;
  logic [VEL_W-1:0] vel_sat;

  assign tc = (win_q == W_LAST);

  // Signed step value, saturating accumulate and output clamp
  always_comb begin
    step_ext = {{VEL_W{step_rev}}, step_fwd | step_rev};
    acc_sum  = {acc_q[VEL_W], acc_q} + {step_ext[VEL_W], step_ext};
    if (acc_sum[VEL_W+1] != acc_sum[VEL_W]) begin
      acc_next = {acc_sum[VEL_W+1], {VEL_W{~acc_sum[VEL_W+1]}}};
    end else begin
      acc_next = acc_sum[VEL_W:0];
    end
    if (acc_q[VEL_W] != acc_q[VEL_W-1]) begin
      vel_sat = {acc_q[VEL_W], {(VEL_W-1){~acc_q[VEL_W]}}};
    end else begin
      vel_sat = acc_q[VEL_W-1:0];
    end
  end

  // Window counter, accumulator and velocity report registers
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q       <= '0;
      acc_q       <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      vel_valid_q <= tc;
      if (tc) begin
        win_q    <= '0;
        vel_q    <= vel_sat;
        moving_q <= |vel_sat;
        acc_q    <= step_ext;
      end else begin
        win_q    <= win_q + 1'b1;
        acc_q    <= acc_next;
      end
    end
  end

  assign position  = pos_q;
  assign velocity  = vel_q;
  assign vel_valid = vel_valid_q;
  assign direction = dir_q;
  assign moving    = moving_q;
  assign error     = err_q;
  assign fsm_state = state_q;

endmodule
